// File: rtl/spi_slave_param.sv
// Parametrised SPI slave frame engine: receives {cmd,payload} MSB first, optionally
// streams back a handshaked tx word, and flags aborted frames / read timeouts.
module spi_slave_param #(
    parameter int                 CMD_W      = 2,
    parameter int                 DATA_W     = 8,
    parameter int                 TX_TIMEOUT = 15,
    parameter logic [CMD_W-1:0]   RD_CMD     = '1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SS_n,
    input  logic                      MOSI,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      MISO,
    output logic [CMD_W+DATA_W-1:0]   rx_data,
    output logic                      rx_valid,
    output logic                      tx_ready,
    output logic                      frame_err
);

    localparam int RX_W   = CMD_W + DATA_W;
    localparam int BIT_W  = $clog2(RX_W + 1);
    localparam int TXC_W  = $clog2(DATA_W + 1);
    localparam int WAIT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RECV    = 3'd1;
    localparam logic [2:0] WAIT_TX = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [TXC_W-1:0]  tx_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RX_W-2:0]   shift_reg;
    logic [DATA_W-1:0] tx_shift;
    logic [RX_W-1:0]   rx_word;

    // Word as it stands once the current MOSI bit is included.
    assign rx_word  = {shift_reg, MOSI};
    assign tx_ready = (state == WAIT_TX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_cnt    <= '0;
            wait_cnt  <= '0;
            shift_reg <= '0;
            tx_shift  <= '0;
            MISO      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (SS_n) begin
                // Deselect overrides everything, including the final RECV bit.
                if (state == RECV || state == WAIT_TX || state == SEND)
                    frame_err <= 1'b1;
                state    <= IDLE;
                bit_cnt  <= '0;
                tx_cnt   <= '0;
                wait_cnt <= '0;
                MISO     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                    RECV: begin
                        shift_reg <= rx_word[RX_W-2:0];
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(RX_W - 1)) begin
                            rx_data  <= rx_word;
                            rx_valid <= 1'b1;
                            state    <= (rx_word[RX_W-1 -: CMD_W] == RD_CMD) ? WAIT_TX : DONE;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            // Latched word is kept pre-shifted so SEND always emits its MSB.
                            tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                            MISO     <= tx_data[DATA_W-1];
                            tx_cnt   <= TXC_W'(1);
                            state    <= SEND;
                        end else if (TX_TIMEOUT > 0) begin
                            if (wait_cnt == WAIT_W'(TX_TIMEOUT - 1)) begin
                                state     <= DONE;
                                frame_err <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (tx_cnt < TXC_W'(DATA_W)) begin
                            MISO     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            tx_cnt   <= tx_cnt + 1'b1;
                        end else begin
                            MISO  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        MISO <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        MISO  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: frame-level timing model, directed frame table,
// random frames, plus a wide-configuration read-back sequence.
module tb_spi_slave_param;

    localparam int RX_W   = 10;
    localparam int DATA_W = 8;
    localparam int TO     = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        miso, rx_valid, tx_ready, frame_err;
    logic [9:0]  rx_data;

    logic        ss2 = 1'b1;
    logic        mosi2 = 1'b0;
    logic [15:0] txd2 = '0;
    logic        txv2 = 1'b0;
    logic        miso2, rv2, tr2, fe2;
    logic [18:0] rxd2;

    int total = 0;
    int bad = 0;
    logic [9:0] model_rx = '0;

    always #5 clk = ~clk;

    spi_slave_param u_dut (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
        .tx_data(tx_data), .tx_valid(tx_valid), .MISO(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .frame_err(frame_err)
    );

    spi_slave_param #(.CMD_W(3), .DATA_W(16), .TX_TIMEOUT(15), .RD_CMD(3'b111)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss2), .MOSI(mosi2),
        .tx_data(txd2), .tx_valid(txv2), .MISO(miso2),
        .rx_data(rxd2), .rx_valid(rv2), .tx_ready(tr2),
        .frame_err(fe2)
    );

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] pay;
        int         d;       // tx_valid arrives d edges after the last RX bit
        int         h;       // edge at which SS_n is driven high
        int         rst_at;  // edge at which rst_n is pulsed low (-1: never)
        int         gap;
        logic [7:0] tx_word;
        logic [9:0] exp_rx;
        int         exp_err;
        bit         hand;
    } frame_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t mk(logic [1:0] c, logic [7:0] p, int d, int h, int rst_at,
                                  logic [7:0] tw, logic [9:0] er, int ee);
        frame_t f;
        f.cmd = c; f.pay = p; f.d = d; f.h = h; f.rst_at = rst_at; f.gap = 1;
        f.tx_word = tw; f.exp_rx = er; f.exp_err = ee; f.hand = 1'b1;
        return f;
    endfunction

    // Expected outputs derived from event times relative to the frame start.
    task automatic run_frame(input int idx, input frame_t f);
        logic [9:0] word;
        bit rd, hs, busy;
        int last, errs, bit_i;
        logic e_miso, e_rv, e_tr, e_fe;
        logic [9:0] e_rx;
        word = {f.cmd, f.pay};
        rd   = (f.cmd == 2'b11);
        hs   = rd && (f.d <= TO);
        last = (f.rst_at >= 0) ? f.rst_at : f.h;
        errs = 0;
        for (int j = 0; j <= last; j++) begin
            ss_n  = (j == f.h);
            rst_n = (j != f.rst_at);
            mosi  = (j >= 1 && j <= RX_W) ? word[RX_W-j] : 1'($urandom_range(1, 0));
            if (hs && j == RX_W + f.d) begin
                tx_valid = 1'b1;
                tx_data  = f.tx_word;
            end else if (rd && j > RX_W && j < RX_W + f.d && j <= RX_W + TO) begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end else begin
                tx_valid = 1'($urandom_range(1, 0));
                tx_data  = 8'($urandom);
            end
            step();
            if (j == f.rst_at) begin
                e_miso = 1'b0; e_rv = 1'b0; e_tr = 1'b0; e_fe = 1'b0; e_rx = '0;
            end else begin
                e_rx = (j >= RX_W && f.h > RX_W) ? word : model_rx;
                if (j == f.h) begin
                    busy = (j <= RX_W) ||
                           (rd && (hs ? (j <= RX_W + f.d + DATA_W) : (j <= RX_W + TO)));
                    e_miso = 1'b0; e_rv = 1'b0; e_tr = 1'b0; e_fe = busy;
                end else begin
                    e_rv = (j == RX_W);
                    e_tr = rd && j >= RX_W && (hs ? (j < RX_W + f.d) : (j < RX_W + TO));
                    e_fe = rd && !hs && (j == RX_W + TO);
                    e_miso = 1'b0;
                    if (hs && j >= RX_W + f.d && j < RX_W + f.d + DATA_W) begin
                        bit_i  = DATA_W - 1 - (j - RX_W - f.d);
                        e_miso = f.tx_word[bit_i];
                    end
                end
            end
            check($sformatf("f%0d miso@%0d", idx, j), 32'(miso), 32'(e_miso));
            check($sformatf("f%0d rx_valid@%0d", idx, j), 32'(rx_valid), 32'(e_rv));
            check($sformatf("f%0d tx_ready@%0d", idx, j), 32'(tx_ready), 32'(e_tr));
            check($sformatf("f%0d frame_err@%0d", idx, j), 32'(frame_err), 32'(e_fe));
            check($sformatf("f%0d rx_data@%0d", idx, j), 32'(rx_data), 32'(e_rx));
            if (frame_err === 1'b1) errs++;
        end
        if (f.rst_at >= 0) model_rx = '0;
        else if (f.h > RX_W) model_rx = word;
        for (int g = 0; g < f.gap; g++) begin
            ss_n = 1'b1; rst_n = 1'b1;
            mosi = 1'($urandom_range(1, 0));
            tx_valid = 1'($urandom_range(1, 0));
            step();
            check($sformatf("f%0d gap miso", idx), 32'(miso), 32'd0);
            check($sformatf("f%0d gap flags", idx), {29'd0, rx_valid, tx_ready, frame_err}, 32'd0);
            check($sformatf("f%0d gap rx_data", idx), 32'(rx_data), 32'(model_rx));
        end
        if (f.hand) begin
            check($sformatf("f%0d final rx_data", idx), 32'(rx_data), 32'(f.exp_rx));
            check($sformatf("f%0d err pulses", idx), 32'(errs), 32'(f.exp_err));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        frame_t tbl[13];
        frame_t f;
        logic [15:0] beef;
        int mode, fin;

        tbl[0]  = mk(2'b00, 8'hA5, 1,   RX_W + 3,          -1, 8'h00, 10'h0A5, 0);
        tbl[1]  = mk(2'b01, 8'h3F, 1,   7,                 -1, 8'h00, 10'h0A5, 1);
        tbl[2]  = mk(2'b10, 8'h3C, 1,   RX_W + 1,          -1, 8'h00, 10'h23C, 0);
        tbl[3]  = mk(2'b01, 8'hFF, 1,   RX_W,              -1, 8'h00, 10'h23C, 1);
        tbl[4]  = mk(2'b11, 8'h00, 2,   RX_W + 2 + 8 + 2,  -1, 8'h96, 10'h300, 0);
        tbl[5]  = mk(2'b11, 8'h00, 100, RX_W + TO + 4,     -1, 8'h00, 10'h300, 1);
        tbl[6]  = mk(2'b11, 8'h5A, 15,  RX_W + 15 + 8 + 1, -1, 8'h81, 10'h35A, 0);
        tbl[7]  = mk(2'b11, 8'hA5, 16,  RX_W + 16 + 2,     -1, 8'h00, 10'h3A5, 1);
        tbl[8]  = mk(2'b11, 8'h77, 1,   RX_W + 1 + 4,      -1, 8'hC3, 10'h377, 1);
        tbl[9]  = mk(2'b11, 8'h44, 3,   RX_W + 2,          -1, 8'h00, 10'h344, 1);
        tbl[10] = mk(2'b01, 8'h5A, 1,   RX_W + 14,         -1, 8'h00, 10'h15A, 0);
        tbl[11] = mk(2'b11, 8'h12, 2,   999, RX_W + 2 + 3,     8'h96, 10'h000, 0);
        tbl[12] = mk(2'b00, 8'h3C, 1,   RX_W + 1,          -1, 8'h00, 10'h03C, 0);

        rst_n = 1'b0; ss_n = 1'b0; ss2 = 1'b0; mosi = 1'b1; tx_valid = 1'b1;
        step();
        step();
        check("reset miso", 32'(miso), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset flags", {29'd0, rx_valid, tx_ready, frame_err}, 32'd0);
        check("reset16 outputs", {12'd0, miso2, rv2, tr2, fe2}, 32'd0);
        check("reset16 rx_data", 32'(rxd2), 32'd0);
        rst_n = 1'b1; ss_n = 1'b1; ss2 = 1'b1; tx_valid = 1'b0;
        step();

        for (int i = 0; i < 13; i++) run_frame(i, tbl[i]);

        for (int i = 0; i < 40; i++) begin
            f.cmd = $urandom_range(1, 0) ? 2'b11 : 2'($urandom);
            f.pay = 8'($urandom);
            f.d = int'($urandom_range(20, 1));
            f.tx_word = 8'($urandom);
            f.rst_at = -1;
            f.gap = int'($urandom_range(2, 0));
            f.hand = 1'b0; f.exp_rx = '0; f.exp_err = 0;
            mode = int'($urandom_range(3, 0));
            if (f.cmd != 2'b11) fin = RX_W;
            else if (f.d <= TO) fin = RX_W + f.d + DATA_W;
            else fin = RX_W + TO;
            f.h = (mode == 0) ? int'($urandom_range(fin, 1)) : fin + int'($urandom_range(3, 1));
            run_frame(100 + i, f);
        end

        // Wide configuration: 111 + 0x0000, then 0xBEEF streamed back.
        beef = 16'hBEEF;
        ss2 = 1'b0;
        step();
        for (int i = 0; i < 19; i++) begin
            mosi2 = (i < 3);
            step();
            if (i < 18) check("w16 early rx_valid", 32'(rv2), 32'd0);
        end
        check("w16 rx_valid", 32'(rv2), 32'd1);
        check("w16 rx_data", 32'(rxd2), 32'h70000);
        check("w16 tx_ready", 32'(tr2), 32'd1);
        txv2 = 1'b1; txd2 = beef;
        step();
        txv2 = 1'b0; txd2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("w16 miso bit%0d", i), 32'(miso2), 32'(beef[15-i]));
            check("w16 tx_ready low", 32'(tr2), 32'd0);
            step();
        end
        check("w16 miso tail", 32'(miso2), 32'd0);
        ss2 = 1'b1;
        step();
        check("w16 no err", 32'(fe2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave frame engine; successor to the fixed 10-bit RAM-interface SPI slave.
- Command and payload widths are configurable. Read-back waits for the tx_valid handshake, with an optional timeout.
- Aborted frames are reported explicitly on an error output.
- Sits between the SPI pins and the single-port RAM controller. clk is the SPI bit clock: one MOSI/MISO bit per clk edge.

Parameters:
- CMD_W, 2, command field width. Sent first, MSB first.
- DATA_W, 8, payload width; also the width of tx_data and the read-back shift.
- TX_TIMEOUT, 15, cycles to wait in WAIT_TX for tx_valid. 0 = wait forever.
- RD_CMD, all ones (2'b11 at default), command code that triggers read-back.

Ports:
- clk  in  1  bit clock; all logic on posedge.
- rst_n  in  1  reset.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in, MSB first.
- tx_data  in  DATA_W  read-back word.
- tx_valid  in  1  tx_data valid. Only observed in WAIT_TX.
- MISO  out  1  serial data out.
- rx_data  out  CMD_W+DATA_W  received word {cmd,payload}.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_ready  out  1  high while in WAIT_TX.
- frame_err  out  1  one-cycle pulse: frame aborted or read timeout.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk.
  - MISO=0, rx_data=0, rx_valid=0, tx_ready=0, frame_err=0.
  - State = IDLE; all counters 0.
- RX_W = CMD_W+DATA_W.
- States: IDLE, RECV, WAIT_TX, SEND, DONE.
- IDLE
  - Edge with SS_n=0 → RECV, bit_cnt=0. MOSI is not sampled on this edge (turnaround cycle).
- RECV
  - Each edge: shift MOSI into the internal shift register LSB-side; bit_cnt++.
  - On the RX_W-th sample:
    - rx_data <= complete word; rx_valid=1 for exactly one cycle.
    - If the cmd field == RD_CMD → WAIT_TX, else → DONE.
  - Latency: SS_n low seen at edge 0; bits sampled at edges 1..RX_W; rx_valid high in the cycle after edge RX_W.
  - rx_data holds its value until the next completed frame. Aborted frames never modify rx_data.
- WAIT_TX
  - tx_ready=1.
  - Edge with tx_valid=1:
    - Latch tx_data.
    - MISO <= tx_data[DATA_W-1]; tx_cnt=1.
    - → SEND.
  - Otherwise, with TX_TIMEOUT>0: the wait counter increments each edge. When it reaches TX_TIMEOUT → DONE with a frame_err pulse, MISO stays 0.
- SEND
  - Each edge: if tx_cnt<DATA_W, MISO <= latched[DATA_W-1-tx_cnt] and tx_cnt++. Otherwise MISO <= 0 → DONE.
  - Each bit is held for exactly one cycle.
  - tx_valid is ignored.
- DONE
  - MISO=0; MOSI is ignored until SS_n=1.
- SS_n=1 at any edge in RECV, WAIT_TX, SEND or DONE:
  - → IDLE; counters cleared; MISO <= 0; tx_ready drops.
  - SS_n has priority over every other event, including the edge that would deliver the last RECV bit: no rx_valid on that edge.
  - frame_err pulses if SS_n rises in RECV, WAIT_TX or SEND, i.e. before the frame completed. No pulse from DONE or IDLE.
- Continuously low SS_n after DONE does not start a new frame. SS_n must return high for at least one edge.
- rx_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: all registers return to reset values at that edge; no pulses.

Test Plan:
- Write frame: SS_n low; MOSI = 00 then 0xA5 MSB first (10 bits) → rx_data=0x0A5, rx_valid high exactly 1 cycle after bit 10; state DONE; MISO stays 0.
- Read-back: MOSI = 11 then 0x00 → rx_data=0x300, rx_valid pulse, tx_ready=1. Two cycles later, tx_valid with tx_data=0x96 → MISO = 1,0,0,1,0,1,1,0 on 8 consecutive cycles, then 0; tx_ready low after the handshake.
- Timeout: read frame with tx_valid never asserted, TX_TIMEOUT=15 → frame_err pulse exactly 15 cycles after entering WAIT_TX; MISO remains 0; later tx_valid ignored.
- Abort: SS_n rises after 6 MOSI bits → frame_err pulse, no rx_valid, rx_data keeps the previous 0x0A5. Next full frame 10 + 0x3C → rx_data=0x23C.
- Parametrisation: CMD_W=3, DATA_W=16, RD_CMD=3'b111; MOSI = 111 + 0x0000, then tx_data=0xBEEF → 16-bit MISO stream of 0xBEEF MSB first; rx_data width 19.
- Reset mid-SEND after 3 bits → all outputs 0 next cycle; no frame_err. A subsequent frame operates normally.
